mem_access_ctrl: RTL

Parametrised memory-access sequencer, successor to the CPU's single-beat memory read/write strobe generator. It decodes the instruction opcode when the beat signal `t2` rises, then runs a multi-cycle bus cycle: address setup, active-low read or write strobe held until the memory acknowledges, and recovery. It adds minimum and variable wait states, a timeout with an error flag, read-data capture and a busy/stall output to the timing generator. It sits between the instruction register and datapath on one side and the external data-memory bus on the other.

---
 rtl/mem_access_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: decodes LD/ST on a rising t2 and runs address setup, a strobe held until mem_rdy, then recovery.
// Best case 3 busy cycles; the strobe stays low for max(MIN_WAIT, mem_rdy wait) capped at TIMEOUT; busy stalls the timing generator.
module mem_access_ctrl #(
  parameter int         IR_W     = 16,
  parameter int         ADDR_W   = 16,
  parameter int         DATA_W   = 8,
  parameter logic [3:0] LD_OP    = 4'b0110,
  parameter logic [3:0] ST_OP    = 4'b0111,
  parameter int         MIN_WAIT = 1,
  parameter int         TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t2,
  input  logic [IR_W-1:0]   ir,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              dout_en,
  output logic              nDRD,
  output logic              nDWR,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W1 = CNT_W + 1;
  // Thresholds expressed as strobe-low cycles, compared against cnt+1.
  localparam logic [CNT_W:0] MIN_LOW  = CNT_W1'(MIN_WAIT);
  localparam logic [CNT_W:0] MAX_LOW  = CNT_W1'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state;
  state_t nextState;

  logic             t2Q;
  logic             start;
  logic [3:0]       opcode;
  logic             isLd;
  logic             isSt;
  logic             isMemOp;
  logic             opLoad;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cntPlusOne;
  logic             accessExit;
  logic             accessTimeout;
  logic             unusedIrBits;

  logic              opLoadNxt;
  logic [CNT_W-1:0]  cntNxt;
  logic [ADDR_W-1:0] memAddrNxt;
  logic [DATA_W-1:0] memDoutNxt;
  logic [DATA_W-1:0] rdataNxt;
  logic              doutEnNxt;
  logic              nDRDNxt;
  logic              nDWRNxt;
  logic              busyNxt;
  logic              doneNxt;
  logic              errNxt;

  assign start   = t2 & ~t2Q;
  assign opcode  = ir[IR_W-1 -: 4];
  assign isLd    = (opcode == LD_OP);
  assign isSt    = (opcode == ST_OP);
  assign isMemOp = isLd | isSt;

  // Operand bits of the instruction are decoded by the datapath, not here.
  assign unusedIrBits = ^ir[IR_W-5:0];

  assign cntPlusOne    = {1'b0, cnt} + 1'b1;
  assign accessExit    = mem_rdy && (cntPlusOne >= MIN_LOW);
  assign accessTimeout = !accessExit && (cntPlusOne == MAX_LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t2Q   <= 1'b0;
    end else begin
      state <= nextState;
      t2Q   <= t2;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start && isMemOp) nextState = SETUP;
      SETUP:   nextState = ACCESS;
      ACCESS:  if (accessExit || accessTimeout) nextState = RECOVER;
      RECOVER: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Next values for the output flops; strobes and pulses default inactive.
  always_comb begin
    opLoadNxt  = opLoad;
    cntNxt     = cnt;
    memAddrNxt = mem_addr;
    memDoutNxt = mem_dout;
    rdataNxt   = rdata;
    errNxt     = err;
    doutEnNxt  = 1'b0;
    nDRDNxt    = 1'b1;
    nDWRNxt    = 1'b1;
    busyNxt    = 1'b0;
    doneNxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start && isMemOp) begin
          opLoadNxt  = isLd;
          memAddrNxt = addr_in;
          memDoutNxt = wdata;
          busyNxt    = 1'b1;
          doutEnNxt  = ~isLd;
        end
      end
      SETUP: begin
        busyNxt   = 1'b1;
        cntNxt    = '0;
        nDRDNxt   = ~opLoad;
        nDWRNxt   = opLoad;
        doutEnNxt = ~opLoad;
      end
      ACCESS: begin
        busyNxt = 1'b1;
        if (accessExit) begin
          doneNxt = 1'b1;
          errNxt  = 1'b0;
          if (opLoad) rdataNxt = mem_din;
        end else if (accessTimeout) begin
          doneNxt = 1'b1;
          errNxt  = 1'b1;
        end else begin
          cntNxt    = cnt + 1'b1;
          nDRDNxt   = ~opLoad;
          nDWRNxt   = opLoad;
          doutEnNxt = ~opLoad;
        end
      end
      RECOVER: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opLoad   <= 1'b0;
      cnt      <= '0;
      mem_addr <= '0;
      mem_dout <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      dout_en  <= 1'b0;
      nDRD     <= 1'b1;
      nDWR     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      opLoad   <= opLoadNxt;
      cnt      <= cntNxt;
      mem_addr <= memAddrNxt;
      mem_dout <= memDoutNxt;
      rdata    <= rdataNxt;
      err      <= errNxt;
      dout_en  <= doutEnNxt;
      nDRD     <= nDRDNxt;
      nDWR     <= nDWRNxt;
      busy     <= busyNxt;
      done     <= doneNxt;
    end
  end

endmodule
